// File: rtl/add_slice_sequencer.sv
// add_slice_sequencer
//   Multi-cycle 32-bit add/subtract built on a single SLICE_W-bit
//   ripple-carry slice. The slice is stepped LSB-first across NSLICE byte
//   lanes, and the carry is held in a register between steps. Results are
//   loaded into the output registers in one go as the operation finishes,
//   so partial sums never reach the outputs.
//
//   Optional feature macro: ADD_SEQ_SUB_EN
//     defined   - sub selects A-B (B inverted, carry-in 1)
//     undefined - sub is ignored, every operation is A+B
//
//   Ports
//     clock     rising-edge clock
//     clear     synchronous active-high reset, highest priority
//     start     launch request, sampled in IDLE and on the DONE exit edge
//     sub       1 = A-B, 0 = A+B (sampled with start)
//     A, B      32-bit operands (sampled with start)
//     busy      high in RUN and DONE
//     done      one-cycle pulse while results are fresh
//     Sum       registered 32-bit result
//     CarryOut  carry out of bit 31 (for subtract, 1 = no borrow)
//     Overflow  signed overflow, c31 ^ c32
module add_slice_sequencer #(
  parameter int SLICE_W = 8,
  parameter int NSLICE  = 32 / SLICE_W
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Sum,
  output logic        CarryOut,
  output logic        Overflow
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic          cy_q, cy_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   sum_q, sum_d;
  logic          co_q, co_d;
  logic          ov_q, ov_d;

  // operand conditioning at launch
  logic [31:0] b_in;
  logic        cin;
`ifdef ADD_SEQ_SUB_EN
  assign b_in = sub ? ~B : B;
  assign cin  = sub;
`else
  // sub is kept on the port for interface stability only
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in       = B;
  assign cin        = 1'b0;
`endif

  // shared ripple slice
  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic [SLICE_W:0]   sl_c;

  always_comb begin
    sl_a    = opa_q[idx_q*SLICE_W +: SLICE_W];
    sl_b    = opb_q[idx_q*SLICE_W +: SLICE_W];
    sl_c    = '0;
    sl_sum  = '0;
    sl_c[0] = cy_q;
    for (int i = 0; i < SLICE_W; i++) begin
      sl_sum[i]  = sl_a[i] ^ sl_b[i] ^ sl_c[i];
      sl_c[i+1]  = (sl_a[i] & sl_b[i]) | (sl_c[i] & (sl_a[i] ^ sl_b[i]));
    end
  end

  logic launch;
  assign launch = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cy_d    = cy_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      RUN: begin
        acc_d[idx_q*SLICE_W +: SLICE_W] = sl_sum;
        cy_d  = sl_c[SLICE_W];
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          state_d = DONE;
          // top slice: sl_c[SLICE_W-1] is the carry into bit 31
          sum_d = acc_d;
          co_d  = sl_c[SLICE_W];
          ov_d  = sl_c[SLICE_W-1] ^ sl_c[SLICE_W];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // DONE exit edge may relaunch directly, giving a 5-cycle cadence
    if (launch) begin
      state_d = RUN;
      opa_d   = A;
      opb_d   = b_in;
      cy_d    = cin;
      idx_d   = '0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cy_q    <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cy_q    <= cy_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign Sum      = sum_q;
  assign CarryOut = co_q;
  assign Overflow = ov_q;

endmodule

// File: tb/tb_add_slice_sequencer.sv
module tb_add_slice_sequencer;

  logic        clock = 1'b0;
  logic        clear, start, sub;
  logic [31:0] A, B;
  logic        busy, done, CarryOut, Overflow;
  logic [31:0] Sum;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] last_sum = '0;
  logic last_co = 1'b0, last_ov = 1'b0;

  always #5 clock = ~clock;

  add_slice_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .sub(sub),
    .A(A), .B(B), .busy(busy), .done(done), .Sum(Sum),
    .CarryOut(CarryOut), .Overflow(Overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".sum"},  Sum, 32'd0);
    chk({tag, ".co"},   32'(CarryOut), 32'd0);
    chk({tag, ".ov"},   32'(Overflow), 32'd0);
  endtask

  // one full operation; checks latency, output hold during RUN and results
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] es, input logic eco, input logic eov);
    @(negedge clock);
    A = a; B = b; sub = s; start = 1'b1;
    @(negedge clock);                       // t0 has passed
    chk({tag, ".busy0"}, 32'(busy), 32'd1);
    start = 1'b0; A = $urandom; B = $urandom; sub = ~s;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);                     // after edge t_k
      if (k < 4) begin
        chk({tag, ".done_early"}, 32'(done), 32'd0);
        chk({tag, ".sum_hold"}, Sum, last_sum);
        chk({tag, ".co_hold"}, 32'(CarryOut), 32'(last_co));
      end else begin
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".sum"}, Sum, es);
        chk({tag, ".co"}, 32'(CarryOut), 32'(eco));
        chk({tag, ".ov"}, 32'(Overflow), 32'(eov));
      end
    end
    @(negedge clock);                       // after t5
    chk({tag, ".done_off"}, 32'(done), 32'd0);
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
    chk({tag, ".sum_keep"}, Sum, es);
    last_sum = es; last_co = eco; last_ov = eov;
  endtask

  initial begin
    clear = 1'b1; start = 1'b1; sub = 1'b0; A = $urandom; B = $urandom;
    // reset with start high: clear wins
    @(negedge clock); A = $urandom; B = $urandom;
    @(negedge clock);
    chk_idle_zero("reset");
    clear = 1'b0; start = 1'b0;
    @(negedge clock);
    chk("reset.no_launch", 32'(busy), 32'd0);

    do_op("xslice", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    do_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op("sovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`ifdef ADD_SEQ_SUB_EN
    do_op("sub",    32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
`else
    do_op("sub",    32'd5, 32'd7, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
`endif

    // handshake: start held through RUN/DONE, relaunch at t5
    @(negedge clock);
    A = 32'h1; B = 32'h2; sub = 1'b0; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);                     // after t0..t3
      A = 32'h10 << k; B = 32'h20 << k;      // must be ignored
    end
    @(negedge clock);                       // after t4, in DONE
    chk("hs.done1", 32'(done), 32'd1);
    chk("hs.sum1", Sum, 32'h3);
    A = 32'h100; B = 32'h200;               // sampled at t5
    @(negedge clock);                       // after t5
    chk("hs.relaunch_busy", 32'(busy), 32'd1);
    chk("hs.relaunch_done", 32'(done), 32'd0);
    start = 1'b0; A = $urandom; B = $urandom;
    for (int k = 0; k < 3; k++) @(negedge clock);
    chk("hs.done_early", 32'(done), 32'd0);
    chk("hs.sum_hold", Sum, 32'h3);
    @(negedge clock);                       // after t9
    chk("hs.done2", 32'(done), 32'd1);
    chk("hs.sum2", Sum, 32'h300);
    @(negedge clock);
    chk("hs.idle", 32'(busy), 32'd0);

    // abort: clear lands on the edge ending the second RUN cycle
    A = 32'h1234_5678; B = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    @(negedge clock);                       // after t0
    start = 1'b0;
    @(negedge clock);                       // after t1
    clear = 1'b1;
    @(negedge clock);                       // after t2
    clear = 1'b0;
    chk_idle_zero("abort");
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("abort.no_done", 32'(done), 32'd0);
    end
    last_sum = '0; last_co = 1'b0; last_ov = 1'b0;
    do_op("fresh", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
